// File: rtl/alarm_bank_pkg.sv
// Shared types, BCD limits and helpers for the alarm bank.
// The SNOOZE state exists only when ALARM_BANK_SNOOZE_EN is defined.
package alarm_bank_pkg;

`ifdef ALARM_BANK_SNOOZE_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RING = 2'd1
    } state_t;
`endif

    localparam logic [7:0] BCD_MIN_MAX  = 8'h59;
    localparam logic [7:0] BCD_HOUR_MAX = 8'h23;

    // Bits needed to hold a countdown loaded with 'secs'.
    function automatic int tmr_width(input int secs);
        return $clog2(secs + 1);
    endfunction

    // BCD increment that wraps to 00 once 'max' is reached.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
        logic [7:0] res;
        if (val >= max) begin
            res = 8'h00;
        end else if (val[3:0] >= 4'h9) begin
            res = {val[7:4] + 4'h1, 4'h0};
        end else begin
            res = {val[7:4], val[3:0] + 4'h1};
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_wrap_cnt.sv
// 8-bit BCD up-counter that advances on a one-cycle enable pulse and
// wraps from MAX back to 00.
module bcd_wrap_cnt
    import alarm_bank_pkg::*;
#(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_inc,
    output logic [7:0] o_q
);

    logic [7:0] r_q;

    // Counter register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_q <= 8'h00;
        end else if (i_inc) begin
            r_q <= bcd_inc(r_q, MAX);
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/alarm_bank.sv
// Multi-slot alarm register bank with ring/timeout controller.
// Optional snooze support is built when ALARM_BANK_SNOOZE_EN is defined.
module alarm_bank
    import alarm_bank_pkg::*;
#(
    parameter int NUM_ALARMS     = 4,
    parameter int SEL_W          = 2,
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sec_tick,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  minute_set,
    input  logic                  hour_set,
    input  logic                  en_toggle,
    input  logic                  stop,
    input  logic                  snooze,
    input  logic [7:0]            cur_hour,
    input  logic [7:0]            cur_minute,
    input  logic [7:0]            cur_second,
    output logic [7:0]            second_data,
    output logic [7:0]            minute_data,
    output logic [7:0]            hour_data,
    output logic [NUM_ALARMS-1:0] alarm_en,
    output logic                  ring,
    output logic [SEL_W-1:0]      ring_id
);

    localparam int RING_W = tmr_width(RING_SECONDS);
`ifdef ALARM_BANK_SNOOZE_EN
    localparam int SNOOZE_W = tmr_width(SNOOZE_SECONDS);
    localparam int TMR_W    = (RING_W > SNOOZE_W) ? RING_W : SNOOZE_W;
    localparam logic [TMR_W-1:0] SNOOZE_LOAD = TMR_W'(SNOOZE_SECONDS);
`else
    localparam int TMR_W = RING_W;
`endif
    localparam logic [TMR_W-1:0] RING_LOAD = TMR_W'(RING_SECONDS);
    localparam int SEL_SPAN = 2**SEL_W;

    logic r_min_d, r_hour_d, r_tog_d, r_stop_d;
    logic w_min_edge, w_hour_edge, w_tog_edge, w_stop_edge;
`ifdef ALARM_BANK_SNOOZE_EN
    logic r_snooze_d;
    logic w_snooze_edge;
`else
    logic [10:0] w_unused_snooze;
    assign w_unused_snooze = {snooze, 10'(SNOOZE_SECONDS)};
`endif

    logic [7:0]            w_slot_min  [NUM_ALARMS];
    logic [7:0]            w_slot_hour [NUM_ALARMS];
    logic [7:0]            w_min_pad   [SEL_SPAN];
    logic [7:0]            w_hour_pad  [SEL_SPAN];
    logic [NUM_ALARMS-1:0] w_tog_mask;
    logic [NUM_ALARMS-1:0] w_id_hit;
    logic [NUM_ALARMS-1:0] w_slot_match;
    logic [NUM_ALARMS-1:0] r_alarm_en;
    logic                  w_match_any;
    logic [SEL_W-1:0]      w_match_id;
    logic                  r_match_vld;
    logic [SEL_W-1:0]      r_match_id;
    logic                  w_dis_ring;

    state_t           r_state, w_state_nxt;
    logic [TMR_W-1:0] r_timer, w_timer_nxt, w_timer_dec;
    logic [SEL_W-1:0] r_ring_id, w_ring_id_nxt;
    logic             r_ring;

    // Key history bits for rising-edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_min_d    <= 1'b0;
            r_hour_d   <= 1'b0;
            r_tog_d    <= 1'b0;
            r_stop_d   <= 1'b0;
`ifdef ALARM_BANK_SNOOZE_EN
            r_snooze_d <= 1'b0;
`endif
        end else begin
            r_min_d    <= minute_set;
            r_hour_d   <= hour_set;
            r_tog_d    <= en_toggle;
            r_stop_d   <= stop;
`ifdef ALARM_BANK_SNOOZE_EN
            r_snooze_d <= snooze;
`endif
        end
    end

    assign w_min_edge  = minute_set & ~r_min_d;
    assign w_hour_edge = hour_set & ~r_hour_d;
    assign w_tog_edge  = en_toggle & ~r_tog_d;
    assign w_stop_edge = stop & ~r_stop_d;
`ifdef ALARM_BANK_SNOOZE_EN
    assign w_snooze_edge = snooze & ~r_snooze_d;
`endif

    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_slot
        logic w_hit;
        assign w_hit = (sel == SEL_W'(gi));

        bcd_wrap_cnt #(.MAX(BCD_MIN_MAX)) u_min (
            .i_clock (clock),
            .i_reset (reset),
            .i_inc   (w_min_edge & w_hit),
            .o_q     (w_slot_min[gi])
        );

        bcd_wrap_cnt #(.MAX(BCD_HOUR_MAX)) u_hour (
            .i_clock (clock),
            .i_reset (reset),
            .i_inc   (w_hour_edge & w_hit),
            .o_q     (w_slot_hour[gi])
        );

        assign w_tog_mask[gi]   = w_tog_edge & w_hit;
        assign w_id_hit[gi]     = (r_ring_id == SEL_W'(gi));
        assign w_min_pad[gi]    = w_slot_min[gi];
        assign w_hour_pad[gi]   = w_slot_hour[gi];
        assign w_slot_match[gi] = r_alarm_en[gi] && (cur_second == 8'h00) &&
                                  (w_slot_hour[gi] == cur_hour) &&
                                  (w_slot_min[gi] == cur_minute);
    end

    // Unpopulated select codes read back as 00.
    for (genvar gp = NUM_ALARMS; gp < SEL_SPAN; gp++) begin : g_pad
        assign w_min_pad[gp]  = 8'h00;
        assign w_hour_pad[gp] = 8'h00;
    end

    assign second_data = 8'h00;
    assign minute_data = w_min_pad[sel];
    assign hour_data   = w_hour_pad[sel];

    // Per-slot enable flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_alarm_en <= {NUM_ALARMS{1'b0}};
        end else begin
            r_alarm_en <= r_alarm_en ^ w_tog_mask;
        end
    end

    // Lowest-index matching slot wins; scan high to low so it overrides last.
    always_comb begin
        w_match_any = |w_slot_match;
        w_match_id  = {SEL_W{1'b0}};
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            w_match_id = w_slot_match[i] ? SEL_W'(i) : w_match_id;
        end
    end

    // Match result sampled only on second ticks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_match_vld <= 1'b0;
            r_match_id  <= {SEL_W{1'b0}};
        end else begin
            r_match_vld <= sec_tick & w_match_any;
            r_match_id  <= w_match_id;
        end
    end

    assign w_dis_ring  = |(w_tog_mask & r_alarm_en & w_id_hit);
    assign w_timer_dec = r_timer - TMR_W'(1);

    // Ring controller next state; key edges take priority over tick countdown.
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_ring_id_nxt = r_ring_id;
        case (r_state)
            ST_IDLE: begin
                if (r_match_vld) begin
                    w_state_nxt   = ST_RING;
                    w_timer_nxt   = RING_LOAD;
                    w_ring_id_nxt = r_match_id;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RING: begin
                if (w_stop_edge || w_dis_ring) begin
                    w_state_nxt = ST_IDLE;
`ifdef ALARM_BANK_SNOOZE_EN
                end else if (w_snooze_edge) begin
                    w_state_nxt = ST_SNOOZE;
                    w_timer_nxt = SNOOZE_LOAD;
`endif
                end else if (sec_tick) begin
                    if (w_timer_dec == {TMR_W{1'b0}}) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_timer_nxt = w_timer_dec;
                    end
                end else begin
                    w_state_nxt = ST_RING;
                end
            end
`ifdef ALARM_BANK_SNOOZE_EN
            ST_SNOOZE: begin
                if (w_stop_edge || w_dis_ring) begin
                    w_state_nxt = ST_IDLE;
                end else if (sec_tick) begin
                    if (w_timer_dec == {TMR_W{1'b0}}) begin
                        w_state_nxt = ST_RING;
                        w_timer_nxt = RING_LOAD;
                    end else begin
                        w_timer_nxt = w_timer_dec;
                    end
                end else begin
                    w_state_nxt = ST_SNOOZE;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Ring controller state and registered buzzer request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_timer   <= {TMR_W{1'b0}};
            r_ring_id <= {SEL_W{1'b0}};
            r_ring    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_ring_id <= w_ring_id_nxt;
            r_ring    <= (w_state_nxt == ST_RING);
        end
    end

    assign alarm_en = r_alarm_en;
    assign ring     = r_ring;
    assign ring_id  = r_ring_id;

endmodule

// File: tb/tb_alarm_bank.sv
// Scoreboard bench for alarm_bank: expectations are queued when stimulus is
// applied and compared when the corresponding DUT output is sampled.
`timescale 1ns/1ps
module tb_alarm_bank;

    localparam int NA = 4;
    localparam int SW = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          sec_tick = 1'b0;
    logic [SW-1:0] sel = '0;
    logic          minute_set = 1'b0;
    logic          hour_set = 1'b0;
    logic          en_toggle = 1'b0;
    logic          stop = 1'b0;
    logic          snooze = 1'b0;
    logic [7:0]    cur_hour = 8'h00;
    logic [7:0]    cur_minute = 8'h00;
    logic [7:0]    cur_second = 8'h00;
    logic [7:0]    second_data, minute_data, hour_data;
    logic [NA-1:0] alarm_en;
    logic          ring;
    logic [SW-1:0] ring_id;

    alarm_bank #(
        .NUM_ALARMS(NA), .SEL_W(SW), .RING_SECONDS(3), .SNOOZE_SECONDS(5)
    ) dut (
        .clock(clock), .reset(reset), .sec_tick(sec_tick), .sel(sel),
        .minute_set(minute_set), .hour_set(hour_set), .en_toggle(en_toggle),
        .stop(stop), .snooze(snooze), .cur_hour(cur_hour), .cur_minute(cur_minute),
        .cur_second(cur_second), .second_data(second_data), .minute_data(minute_data),
        .hour_data(hour_data), .alarm_en(alarm_en), .ring(ring), .ring_id(ring_id)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic sb_pop(input logic [31:0] act);
        sb_item_t it;
        if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            it = sb_q.pop_front();
            check_eq(it.tag, act, it.exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic set_key(input int key, input logic v);
        case (key)
            0: minute_set = v;
            1: hour_set   = v;
            2: en_toggle  = v;
            3: stop       = v;
            4: snooze     = v;
            default: ;
        endcase
    endtask

    // Key held for two cycles, then released: must give exactly one action.
    task automatic press(input int key);
        set_key(key, 1'b1);
        cyc(2);
        set_key(key, 1'b0);
        cyc(1);
    endtask

    task automatic press_n(input int key, input int n);
        repeat (n) press(key);
    endtask

    task automatic sec_pulse();
        sec_tick = 1'b1;
        cyc(1);
        sec_tick = 1'b0;
        cyc(1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic set_slot(input int slot, input int hh, input int mm);
        sel = SW'(slot);
        press_n(1, hh);
        press_n(0, mm);
        press(2);
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        cur_hour   = h;
        cur_minute = m;
        cur_second = s;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, sampled while reset is held.
        sb_push("rst_sec", 32'h00);
        sb_push("rst_min", 32'h00);
        sb_push("rst_hour", 32'h00);
        sb_push("rst_en", 32'h0);
        sb_push("rst_ring", 32'h0);
        sb_push("rst_id", 32'h0);
        cyc(2);
        sb_pop(second_data); sb_pop(minute_data); sb_pop(hour_data);
        sb_pop(alarm_en); sb_pop(ring); sb_pop(ring_id);
        reset = 1'b0;
        cyc(1);

        // BCD wrap behaviour on slot 0.
        sel = 3'd0;
        sb_push("min_59", 32'h59);
        press_n(0, 59);
        sb_pop(minute_data);
        sb_push("min_wrap", 32'h01);
        press_n(0, 2);
        sb_pop(minute_data);
        sb_push("no_carry", 32'h00);
        sb_pop(hour_data);
        sb_push("hour_23", 32'h23);
        press_n(1, 23);
        sb_pop(hour_data);
        sb_push("hour_wrap", 32'h00);
        press(1);
        sb_pop(hour_data);
        sb_push("held_key", 32'h02);
        minute_set = 1'b1;
        cyc(6);
        minute_set = 1'b0;
        cyc(1);
        sb_pop(minute_data);

        // Slot isolation and out-of-range select.
        sel = 3'd1;
        sb_push("slot1_iso", 32'h00);
        #1;
        sb_pop(minute_data);
        sel = 3'd5;
        sb_push("oor_data", 32'h00);
        sb_push("oor_en", 32'h0);
        press(2);
        press(0);
        sb_pop(minute_data);
        sb_pop(alarm_en);
        sel = 3'd0;
        sb_push("oor_no_write", 32'h02);
        #1;
        sb_pop(minute_data);

        // Single slot ring and timeout.
        do_reset();
        set_slot(2, 7, 30);
        sb_push("s2_en", 32'h4);
        sb_push("s2_min", 32'h30);
        sb_push("s2_hour", 32'h07);
        #1;
        sb_pop(alarm_en); sb_pop(minute_data); sb_pop(hour_data);
        set_time(8'h07, 8'h29, 8'h59);
        sb_push("pre_match", 32'h0);
        sec_pulse();
        sb_pop(ring);
        set_time(8'h07, 8'h30, 8'h00);
        sb_push("ring_on", 32'h1);
        sb_push("ring_id2", 32'h2);
        sec_pulse();
        sb_pop(ring); sb_pop(ring_id);
        cur_second = 8'h01;
        sb_push("ring_2tick", 32'h1);
        sec_pulse();
        sec_pulse();
        sb_pop(ring);
        sb_push("ring_timeout", 32'h0);
        sec_pulse();
        sb_pop(ring);

        // Priority between simultaneous matches; stop drops the loser.
        do_reset();
        set_slot(1, 6, 0);
        set_slot(3, 6, 0);
        set_time(8'h06, 8'h00, 8'h00);
        sb_push("dual_ring", 32'h1);
        sb_push("dual_id", 32'h1);
        sec_pulse();
        sb_pop(ring); sb_pop(ring_id);
        sb_push("stop", 32'h0);
        press(3);
        sb_pop(ring);
        sb_push("no_replay", 32'h0);
        cyc(5);
        sb_pop(ring);

        // Stop and snooze together: stop wins, nothing comes back later.
        sb_push("ring_again", 32'h1);
        sec_pulse();
        sb_pop(ring);
        stop = 1'b1;
        snooze = 1'b1;
        sb_push("stop_snz_now", 32'h0);
        cyc(1);
        sb_pop(ring);
        stop = 1'b0;
        snooze = 1'b0;
        cur_second = 8'h01;
        sb_push("stop_snz_later", 32'h0);
        repeat (7) sec_pulse();
        sb_pop(ring);

        // Disabling the ringing slot forces idle next cycle.
        cur_second = 8'h00;
        sb_push("dis_ring_on", 32'h1);
        sec_pulse();
        sb_pop(ring);
        sel = 3'd1;
        en_toggle = 1'b1;
        sb_push("dis_ring_off", 32'h0);
        cyc(1);
        sb_pop(ring);
        en_toggle = 1'b0;
        cyc(1);
        sb_push("dis_en", 32'h8);
        sb_pop(alarm_en);

        // Editing the ringing slot does not disturb the ring.
        sb_push("edit_ring_id", 32'h3);
        sec_pulse();
        sb_pop(ring_id);
        sel = 3'd3;
        sb_push("edit_ring", 32'h1);
        sb_push("edit_min", 32'h01);
        press(0);
        sb_pop(ring); sb_pop(minute_data);
        press(3);

        // Snooze behaviour (or its absence).
        do_reset();
        set_slot(2, 8, 15);
        set_time(8'h08, 8'h15, 8'h00);
        sb_push("snz_ring", 32'h1);
        sec_pulse();
        sb_pop(ring);
        cur_second = 8'h01;
`ifdef ALARM_BANK_SNOOZE_EN
        sb_push("snz_quiet", 32'h0);
        press(4);
        sb_pop(ring);
        sb_push("snz_4tick", 32'h0);
        repeat (4) sec_pulse();
        sb_pop(ring);
        sb_push("snz_rering", 32'h1);
        sb_push("snz_id", 32'h2);
        sec_pulse();
        sb_pop(ring); sb_pop(ring_id);
`else
        sb_push("snz_ignored", 32'h1);
        press(4);
        sb_pop(ring);
`endif
        press(3);

        // Asynchronous reset in the middle of a ring.
        cur_second = 8'h00;
        sb_push("pre_rst_ring", 32'h1);
        sec_pulse();
        sb_pop(ring);
        reset = 1'b1;
        #1;
        sb_push("async_rst", 32'h0);
        sb_pop(ring);
        cyc(1);
        reset = 1'b0;
        cyc(1);
        sel = 3'd2;
        sb_push("post_en", 32'h0);
        sb_push("post_min", 32'h00);
        sb_push("post_hour", 32'h00);
        sb_push("post_id", 32'h0);
        #1;
        sb_pop(alarm_en); sb_pop(minute_data); sb_pop(hour_data); sb_pop(ring_id);

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
